store_monitor: RTL

- Passive responder on the processor's data-memory store interface (MemWrite, DataAdr, WriteData); it sits beside `top` in simulation and FPGA bring-up.
- Timestamps every store the CPU issues and buffers it in a small FIFO, which a host drains over a valid/ready port.
- Decodes a pass/fail mailbox address and runs a cycle watchdog, replacing manual waveform inspection with a hardware verdict.

---
 rtl/store_monitor.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/store_monitor.sv
// Store monitor: watches the CPU data-memory store port, timestamps and buffers
// every store in a FWFT FIFO for a host to drain, and produces a pass/fail/timeout
// verdict from a mailbox address and a cycle watchdog.
module store_monitor #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned MAX_CYCLES = 200,
  parameter logic [31:0] PASS_ADDR  = 32'd100,
  parameter logic [31:0] PASS_DATA  = 32'd25,
  parameter int unsigned CW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWrite,
  input  logic [31:0]   DataAdr,
  input  logic [31:0]   WriteData,
  output logic          log_valid,
  input  logic          log_ready,
  output logic [31:0]   log_addr,
  output logic [31:0]   log_data,
  output logic [CW-1:0] log_cycle,
  output logic          overflow,
  output logic [CW-1:0] cycle_count,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic          timeout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CntSat = '1;
  localparam logic [63:0] WdLast = 64'(MAX_CYCLES) - 64'd1;

  typedef enum logic [1:0] {
    StRun,
    StPass,
    StFail,
    StTimeout
  } state_e;

  state_e r_state;
  state_e w_state_d;

  logic [CW-1:0] r_cycle_count;
  logic          w_mailbox;
  logic          w_wd_expired;

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [31:0]   r_addr_mem  [DEPTH];
  logic [31:0]   r_data_mem  [DEPTH];
  logic [CW-1:0] r_cycle_mem [DEPTH];
  logic          r_overflow;

  logic          w_empty;
  logic          w_full;
  logic          w_push_req;
  logic          w_pop;
  logic          w_push;

  assign w_mailbox    = MemWrite && (DataAdr == PASS_ADDR);
  assign w_wd_expired = (64'(r_cycle_count) == WdLast);

  // Verdict FSM next state; a mailbox store outranks a same-cycle watchdog expiry.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StRun: begin
        if (w_mailbox) begin
          w_state_d = (WriteData == PASS_DATA) ? StPass : StFail;
        end else if (w_wd_expired) begin
          w_state_d = StTimeout;
        end
      end
      default: w_state_d = r_state;
    endcase
  end

  // Verdict FSM state register; terminal states are left only through reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Cycle counter advances only while staying in RUN, so it freezes at the deciding
  // value and never wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle_count <= '0;
    end else if ((r_state == StRun) && (w_state_d == StRun) && (r_cycle_count != CntSat)) begin
      r_cycle_count <= r_cycle_count + CW'(1);
    end
  end

  // FIFO control: a pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_push_req = (r_state == StRun) && MemWrite;
  assign w_pop      = !w_empty && log_ready;
  assign w_push     = w_push_req && (!w_full || w_pop);

  // FIFO pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
      end
    end
  end

  // FIFO storage; unread slots are masked at the output so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_wr_ptr[AW-1:0]]  <= DataAdr;
      r_data_mem[r_wr_ptr[AW-1:0]]  <= WriteData;
      r_cycle_mem[r_wr_ptr[AW-1:0]] <= r_cycle_count;
    end
  end

  // Sticky overflow: a store was dropped because no slot was free.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_push_req && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  // Head-of-queue outputs (first-word-fall-through), zero while empty.
  always_comb begin
    log_valid = !w_empty;
    log_addr  = '0;
    log_data  = '0;
    log_cycle = '0;
    if (!w_empty) begin
      log_addr  = r_addr_mem[r_rd_ptr[AW-1:0]];
      log_data  = r_data_mem[r_rd_ptr[AW-1:0]];
      log_cycle = r_cycle_mem[r_rd_ptr[AW-1:0]];
    end
  end

  assign overflow    = r_overflow;
  assign cycle_count = r_cycle_count;
  assign pass        = (r_state == StPass);
  assign fail        = (r_state == StFail);
  assign timeout     = (r_state == StTimeout);
  assign done        = pass | fail | timeout;

endmodule
